// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and bit-timing helper
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic int uart_cpb(input int freq, input int bauds);
    return freq / bauds;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-queue pop handshake between UART and SoC bus
interface uart_rx_fifo_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO shared by the UART RX and TX queues
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o    = (count_q == FULL_COUNT);
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full queue still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive deframer (N-8-1, mid-bit sampling) feeding a byte queue
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FREQ_HZ    = 12_000_000,
  parameter int BAUDS      = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_ni,
  input  logic           rx_i,
  input  logic           clear_i,
  output logic           busy_o,
  output logic           frame_err_o,
  output logic           overrun_o,
  uart_rx_fifo_if.master bus
);

  localparam int CPB = uart_cpb(FREQ_HZ, BAUDS);
  localparam int CNTW = $clog2(CPB);
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CPB / 2 - 1);
  localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CPB - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx_fifo needs at least 4 clocks per bit");
  end

  rx_state_t       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic            rx_prev_q, rx_prev_d;
  logic [1:0]      arm_q, arm_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            fall;
  logic            push;
  logic            ferr_set;
  logic            ovr_set;
  logic            fifo_full;
  logic            fifo_empty;

  assign fall = rx_prev_q & ~rx_s_q;

  // The sync chain's reset 1s are not real line samples, so rx_prev only
  // follows rx_s once both stages hold post-reset values.
  always_comb begin
    rx_meta_d = rx_i;
    rx_s_d    = rx_meta_q;
    arm_d     = {arm_q[0], 1'b1};
    rx_prev_d = rx_s_q & arm_q[1];

    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          state_d  = IDLE;
          push     = rx_s_q;
          ferr_set = ~rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // When full, the queue is non-empty, so ready alone decides whether the head leaves.
    ovr_set = push & fifo_full & ~bus.ready_i;
    ferr_d  = ferr_set | (ferr_q & ~clear_i);
    ovr_d   = ovr_set | (ovr_q & ~clear_i);
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b0;
      arm_q     <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      arm_q     <= arm_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_ni    (reset_ni),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (bus.ready_i),
    .rd_data_o   (bus.data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.valid_o = ~fifo_empty;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the SoC UART: takes the raw `rx_i` pin, synchronises it, deframes BAUDS-N-8-1 characters by mid-bit sampling, and queues received bytes in a small show-ahead FIFO. The SoC bus side pops bytes through a valid/ready handshake. Sticky error flags feed the UART status register at 0x00002004.

## Interface
- `FREQ_HZ`, 12_000_000: core clock frequency.
- `BAUDS`, 115200: line rate.
- `FIFO_DEPTH`, 4: receive queue entries; power of two, ≥2.
- `CPB` (localparam), FREQ_HZ/BAUDS (integer division): clocks per bit. Elaboration error if CPB < 4.
- `clk`  in  1  single core clock.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  asynchronous serial line; idle high.
- `data_o`  out  8  head-of-FIFO byte; valid only while `valid_o`=1.
- `valid_o`  out  1  FIFO not empty.
- `ready_i`  in  1  consumer pops the head when `valid_o & ready_i`.
- `busy_o`  out  1  deframer not in IDLE.
- `frame_err_o`  out  1  sticky: a stop bit sampled low.
- `overrun_o`  out  1  sticky: a good byte was dropped because the FIFO was full.
- `clear_i`  in  1  clears both sticky flags; same-cycle new error wins.

## Operation
- Sync chain: two flops with reset value 1 produce `rx_s`. A `rx_prev` register resets to 0. A falling edge is `rx_prev & ~rx_s`, so a line held low through reset release never starts a frame.
- Deframer FSM:
  - IDLE: on a falling edge → START, counter=0.
  - START: count to CPB/2−1, then sample `rx_s`. If 1 (glitch) → IDLE with nothing recorded. Else → DATA, bit index 0.
  - DATA: every CPB clocks sample one bit into the shift register, LSB first. After bit 7 → STOP.
  - STOP: after CPB clocks sample `rx_s`. If 1, push the byte; if 0, set `frame_err_o` and drop the byte. Either way → IDLE. A new start edge is accepted from the next cycle.
- FIFO push rules:
  - Push accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the byte is dropped and `overrun_o` is set. FIFO contents are unchanged.
- FIFO:
  - Show-ahead: `data_o` is the head entry combinationally from the storage registers.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored (`valid_o`=0) and the push is stored.
  - Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH+1).
- `busy_o` = (state ≠ IDLE).

## Timing
- Reset values:
  - `valid_o`=0, `busy_o`=0, `frame_err_o`=0, `overrun_o`=0, `data_o`=0.
  - FIFO empty, pointers 0, FSM in IDLE.
  - Reset asserted mid-frame or with data queued discards everything immediately (asynchronous).
- Let t0 be the first rising edge at which `rx_i` is low. `rx_s` falls at t0+2 = T, and the FSM enters START at T+1.
- Sample instants:
  - Start sample at T+CPB/2.
  - Data bit k (0..7) at T+CPB/2+(k+1)·CPB.
  - Stop bit at T+CPB/2+9·CPB.
- `valid_o` rises one cycle after the stop sample. Total latency from t0 is 3+CPB/2+9·CPB cycles.
- `busy_o` goes high at T+1 and drops one cycle after the stop sample.
- Pop takes effect at the clock edge; the next entry appears on `data_o` the following cycle.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, STOP}.
  - Shared `uart_cpb(freq, bauds)` constant function, also used by the TX side.
- Sub-module `sync_fifo #(WIDTH, DEPTH)`:
  - Push/pop, full/empty, count.
  - Same-cycle full push+pop allowed.
  - Reusable for the TX queue.

## Test plan
All scenarios use FREQ_HZ=1_000_000, BAUDS=125_000 (CPB=8).
- Send 0xA5 cleanly → `valid_o` rises exactly 79 cycles after t0 with `data_o`=0xA5; pop → `valid_o`=0; no flags set.
- Send 5 bytes 0x01..0x05 with `ready_i`=0 (depth 4) → FIFO holds 0x01..0x04, `overrun_o`=1. Then pop in the stop-sample cycle of a 6th byte 0x06 while full → 0x06 is accepted, count stays 4.
- Frame 0x3C with stop bit driven low → no push, `frame_err_o`=1. Assert `clear_i` → flag 0 next cycle. A following good frame 0x7E is received.
- Low glitch of 2 cycles on `rx_i` → START aborts at the start sample, `busy_o` high for exactly CPB/2 cycles, no push, no flags.
- Assert `reset_ni` low at data bit 4 while the line is low, release mid-frame → no start until the line goes high then low again. The next clean frame 0x55 is received correctly.
- Back-to-back frames with zero idle between stop and next start (0xFF, 0x00) → both received in order. `ready_i` held 1 → each byte visible for exactly one cycle.
